id_gen: RTL



---
 rtl/id_gen_pkg.sv | 33 +++
 rtl/id_gen_wrapctr.sv | 36 +++
 rtl/id_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/id_gen_pkg.sv
// Shared encodings for the identifier generator and the downstream recognizer.
package id_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LETTER = 2'd1,
        ST_DIGIT  = 2'd2,
        ST_TERM   = 2'd3
    } state_t;

    // Recognizer states; S2 means "letter followed by at least one digit".
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } rec_t;

    localparam logic [7:0] ASCII_A      = 8'h61;
    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] TERM_DEFAULT = 8'h20;

    localparam logic [4:0] LET_MOD = 5'd26;
    localparam logic [3:0] DIG_MOD = 4'd10;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7a)) || ((c >= 8'h41) && (c <= 8'h5a));
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

endpackage

// File: rtl/id_gen_wrapctr.sv
// Loadable modulo-N up-counter; o_next exposes the value the counter takes at the next edge.
module id_gen_wrapctr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic [W-1:0] i_modulus,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_next
);

    logic [W-1:0] r_count;

    always_comb begin
        o_next = r_count;
        if (i_load) begin
            o_next = i_load_val;
        end else if (i_inc) begin
            o_next = (r_count == i_modulus - W'(1)) ? '0 : r_count + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= o_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/id_gen.sv
// Identifier character-stream source: L letters, D digits, one terminator, valid/ready paced.
// Optional recognizer shadow output `match` is built when ID_GEN_MATCH_EN is defined.
module id_gen
    import id_gen_pkg::*;
#(
    parameter int         CNT_W     = 4,
    parameter logic [7:0] TERM_CHAR = TERM_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] let_cnt,
    input  logic [CNT_W-1:0] dig_cnt,
    input  logic [4:0]       let_base,
    input  logic [3:0]       dig_base,
    input  logic             char_ready,
    output logic [7:0]       char_out,
    output logic             char_valid,
    output logic             busy,
    output logic             done
`ifdef ID_GEN_MATCH_EN
    ,
    output logic             match
`endif
);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_let_rem, r_dig_rem, w_let_rem_next, w_dig_rem_next;
    logic [7:0]       r_char_out, w_char_next;
    logic             r_char_valid, r_busy, r_done;
    logic             w_xfer, w_start_ok;
    logic [4:0]       w_let_base_c, w_let_cur, w_let_next;
    logic [3:0]       w_dig_base_c, w_dig_cur, w_dig_next;

    assign w_xfer       = r_char_valid && char_ready;
    assign w_start_ok   = (r_state == ST_IDLE) && start;
    assign w_let_base_c = (let_base > 5'd25) ? 5'd0 : let_base;
    assign w_dig_base_c = (dig_base > 4'd9) ? 4'd0 : dig_base;

    id_gen_wrapctr #(.W(5)) u_let_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start_ok),
        .i_load_val (w_let_base_c),
        .i_inc      ((r_state == ST_LETTER) && w_xfer),
        .i_modulus  (LET_MOD),
        .o_count    (w_let_cur),
        .o_next     (w_let_next)
    );

    id_gen_wrapctr #(.W(4)) u_dig_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start_ok),
        .i_load_val (w_dig_base_c),
        .i_inc      ((r_state == ST_DIGIT) && w_xfer),
        .i_modulus  (DIG_MOD),
        .o_count    (w_dig_cur),
        .o_next     (w_dig_next)
    );

    always_comb begin
        w_state_next   = r_state;
        w_let_rem_next = r_let_rem;
        w_dig_rem_next = r_dig_rem;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_let_rem_next = let_cnt;
                    w_dig_rem_next = dig_cnt;
                    if (let_cnt != '0)      w_state_next = ST_LETTER;
                    else if (dig_cnt != '0) w_state_next = ST_DIGIT;
                    else                    w_state_next = ST_TERM;
                end
            end
            ST_LETTER: begin
                if (w_xfer) begin
                    w_let_rem_next = r_let_rem - CNT_W'(1);
                    if (r_let_rem == CNT_W'(1)) begin
                        w_state_next = (r_dig_rem != '0) ? ST_DIGIT : ST_TERM;
                    end
                end
            end
            ST_DIGIT: begin
                if (w_xfer) begin
                    w_dig_rem_next = r_dig_rem - CNT_W'(1);
                    if (r_dig_rem == CNT_W'(1)) w_state_next = ST_TERM;
                end
            end
            ST_TERM: begin
                if (w_xfer) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Character is decoded from next-state values so char_out is a true register.
    always_comb begin
        w_char_next = 8'h00;
        case (w_state_next)
            ST_LETTER: w_char_next = ASCII_A + {3'b000, w_let_next};
            ST_DIGIT:  w_char_next = ASCII_0 + {4'b0000, w_dig_next};
            ST_TERM:   w_char_next = TERM_CHAR;
            default:   w_char_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_let_rem    <= '0;
            r_dig_rem    <= '0;
            r_char_out   <= 8'h00;
            r_char_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_let_rem    <= w_let_rem_next;
            r_dig_rem    <= w_dig_rem_next;
            r_char_out   <= w_char_next;
            r_char_valid <= (w_state_next != ST_IDLE);
            r_busy       <= (w_state_next != ST_IDLE);
            r_done       <= (r_state == ST_TERM) && w_xfer;
        end
    end

    assign char_out   = r_char_out;
    assign char_valid = r_char_valid;
    assign busy       = r_busy;
    assign done       = r_done;

    // Current counter values are not needed outside the counters themselves.
    logic w_unused;
    assign w_unused = ^{w_let_cur, w_dig_cur};

`ifdef ID_GEN_MATCH_EN
    rec_t r_rec, w_rec_next;

    always_comb begin
        w_rec_next = r_rec;
        if (w_xfer) begin
            if (is_letter(r_char_out))     w_rec_next = S1;
            else if (is_digit(r_char_out)) w_rec_next = (r_rec == S0) ? S0 : S2;
            else                           w_rec_next = S0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rec <= S0;
        else       r_rec <= w_rec_next;
    end

    assign match = (r_rec == S2);
`endif

endmodule
